hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have ports: clock  in  1  single rising-edge clock; reset_0  in  1  asynchronous active-low reset.
REQ-002 The block SHALL have ID inputs: rs_id, rt_id  in  5 each  source regs; use_rs_id, use_rt_id  in  1 each  source actually read; branch_taken_id  in  1  branch resolved taken in ID.
REQ-003 The block SHALL have EX/MEM inputs: rw_ex  in  5; wreg_ex, m2reg_ex  in  1; rw_mem  in  5; wreg_mem  in  1; mem_busy  in  1  data memory wait.
REQ-004 The block SHALL have outputs: stall_pc  out  1; stall_ifid  out  1; flush_ifid  out  1; bubble_idex  out  1  zero ID/EX controls; freeze  out  1  hold ID/EX, EX/MEM, MEM/WB; fwd_a_ex, fwd_b_ex  out  2 each  EX operand source.
REQ-005 The fwd encoding SHALL be: 00 regfile/ID/EX value, 01 EX/MEM ALU result, 10 MEM/WB result; 11 unused.

Function
REQ-006 The FSM SHALL have states RUN and MEM_WAIT.
REQ-007 RUN->MEM_WAIT SHALL occur when mem_busy=1; MEM_WAIT->RUN on the first edge with mem_busy=0.
REQ-008 Freeze condition: mem_busy=1 in any state SHALL drive stall_pc=stall_ifid=freeze=1, bubble_idex=flush_ifid=0, same cycle (combinational).
REQ-009 Load-use: lu = wreg_ex & m2reg_ex & rw_ex!=0 & ((use_rs_id & rs_id==rw_ex) | (use_rt_id & rt_id==rw_ex)).
REQ-010 lu=1 with no freeze SHALL drive stall_pc=stall_ifid=bubble_idex=1 for exactly that cycle; one bubble only.
REQ-011 branch_taken_id=1 with no freeze and lu=0 SHALL drive flush_ifid=1 for one cycle; a taken branch under lu SHALL be ignored that cycle.
REQ-012 Priority: freeze > load-use > branch flush.
REQ-013 Forward select, per operand: 01 if wreg_ex & rw_ex!=0 & src==rw_ex & !m2reg_ex; else 10 if wreg_mem & rw_mem!=0 & src==rw_mem; else 00; unused source (use_*=0) SHALL give 00.
REQ-014 EX/MEM match SHALL win over MEM/WB match for the same register.
REQ-015 fwd_a_ex/fwd_b_ex SHALL be registered, 1-cycle latency, aligned with the ID/EX register contents.
REQ-016 On a bubble edge fwd regs SHALL load 00; on freeze edges they SHALL hold; otherwise they SHALL load the computed select.
REQ-017 Register 0 SHALL never be forwarded or cause a stall.

Reset
REQ-018 While reset_0=0: state=RUN, fwd_a_ex=fwd_b_ex=00, all combinational outputs SHALL be 0 regardless of inputs.
REQ-019 Reset asserted during MEM_WAIT SHALL return to RUN immediately; the first edge after release SHALL evaluate inputs normally.

Configuration
REQ-020 Macro HAZARD_STATS_EN defined SHALL add outputs stall_cnt  out  16 and flush_cnt  out  16, each +1 per stalled/flushed clock edge, saturating at 16'hFFFF, cleared by reset.
REQ-021 Without HAZARD_STATS_EN those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-022 A shared package pipe_pkg SHALL hold the FSM state type (RUN, MEM_WAIT), FWD_RF/FWD_EXMEM/FWD_MEMWB constants and the 5-bit register-index width.
REQ-023 One combinational sub-module fwd_sel SHALL compute one operand's 2-bit select; it SHALL be instantiated twice.

Verification
REQ-024 lw writes r5 in EX (wreg_ex=m2reg_ex=1, rw_ex=5), ID uses rs=5 -> stall_pc=stall_ifid=bubble_idex=1 one cycle; next edge fwd_a_ex=00.
REQ-025 add writes r3 in EX, ID rt=3, r3 also in MEM -> after edge fwd_b_ex=01.
REQ-026 mem_busy high 3 cycles with branch_taken_id=1 -> freeze=1 for 3 cycles, flush_ifid=0, state MEM_WAIT then RUN, fwd regs held.
REQ-027 rw_ex=0, wreg_ex=m2reg_ex=1, rs_id=0 -> no stall, fwd 00.
REQ-028 Branch taken with lu=1 -> flush_ifid=0, bubble_idex=1; next cycle branch taken, lu=0 -> flush_ifid=1.
REQ-029 HAZARD_STATS_EN: 70000 consecutive stall edges -> stall_cnt=16'hFFFF; reset_0 low -> 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller: FSM state,
// forward-select codes and register-index width.
package pipe_pkg;

    localparam int REG_W = 5;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Forward-source select for one EX operand. Purely combinational; the caller
// registers the result alongside the ID/EX pipeline register.
module fwd_sel
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] src_i,
    input  logic             use_src_i,
    input  logic [REG_W-1:0] rw_ex_i,
    input  logic             wreg_ex_i,
    input  logic             m2reg_ex_i,
    input  logic [REG_W-1:0] rw_mem_i,
    input  logic             wreg_mem_i,
    output logic [1:0]       sel_o
);

    logic hit_ex;
    logic hit_mem;

    // r0 is hard-wired zero, so a write to it is never a forwarding source.
    assign hit_ex  = wreg_ex_i  && (rw_ex_i  != '0) && (src_i == rw_ex_i) && !m2reg_ex_i;
    assign hit_mem = wreg_mem_i && (rw_mem_i != '0) && (src_i == rw_mem_i);

    always_comb begin
        sel_o = FWD_RF;
        if (use_src_i) begin
            if (hit_ex) begin
                sel_o = FWD_EXMEM;
            end else if (hit_mem) begin
                sel_o = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, load-use bubble, taken-branch
// flush and registered EX forward selects. Define HAZARD_STATS_EN for counters.
module hazard_ctrl
    import pipe_pkg::*;
(
    input  logic             clock,
    input  logic             reset_0,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             use_rs_id,
    input  logic             use_rt_id,
    input  logic             branch_taken_id,
    input  logic [REG_W-1:0] rw_ex,
    input  logic             wreg_ex,
    input  logic             m2reg_ex,
    input  logic [REG_W-1:0] rw_mem,
    input  logic             wreg_mem,
    input  logic             mem_busy,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             flush_ifid,
    output logic             bubble_idex,
    output logic             freeze,
    output logic [1:0]       fwd_a_ex,
    output logic [1:0]       fwd_b_ex
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]      stall_cnt,
    output logic [15:0]      flush_cnt
`endif
);

    state_t     state_q, state_d;
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;
    logic [1:0] sel_a, sel_b;
    logic       lu;
    logic       rs_hit, rt_hit;

    assign rs_hit = use_rs_id && (rs_id == rw_ex);
    assign rt_hit = use_rt_id && (rt_id == rw_ex);
    assign lu     = wreg_ex && m2reg_ex && (rw_ex != '0) && (rs_hit || rt_hit);

    fwd_sel u_fwd_a (
        .src_i      (rs_id),
        .use_src_i  (use_rs_id),
        .rw_ex_i    (rw_ex),
        .wreg_ex_i  (wreg_ex),
        .m2reg_ex_i (m2reg_ex),
        .rw_mem_i   (rw_mem),
        .wreg_mem_i (wreg_mem),
        .sel_o      (sel_a)
    );

    fwd_sel u_fwd_b (
        .src_i      (rt_id),
        .use_src_i  (use_rt_id),
        .rw_ex_i    (rw_ex),
        .wreg_ex_i  (wreg_ex),
        .m2reg_ex_i (m2reg_ex),
        .rw_mem_i   (rw_mem),
        .wreg_mem_i (wreg_mem),
        .sel_o      (sel_b)
    );

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (mem_busy)  state_d = MEM_WAIT;
            MEM_WAIT: if (!mem_busy) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // Freeze follows mem_busy directly in both states so the very first wait
    // cycle is already frozen; the state only records that a wait is ongoing.
    always_comb begin
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        flush_ifid  = 1'b0;
        bubble_idex = 1'b0;
        freeze      = 1'b0;
        if (reset_0) begin
            if (mem_busy) begin
                stall_pc   = 1'b1;
                stall_ifid = 1'b1;
                freeze     = 1'b1;
            end else if (lu) begin
                stall_pc    = 1'b1;
                stall_ifid  = 1'b1;
                bubble_idex = 1'b1;
            end else if (branch_taken_id) begin
                flush_ifid = 1'b1;
            end
        end
    end

    always_comb begin
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (!mem_busy) begin
            fwd_a_d = lu ? FWD_RF : sel_a;
            fwd_b_d = lu ? FWD_RF : sel_b;
        end
    end

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a_ex = fwd_a_q;
    assign fwd_b_ex = fwd_b_q;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_pc)   stall_cnt_q <= sat_inc16(stall_cnt_q);
            if (flush_ifid) flush_cnt_q <= sat_inc16(flush_cnt_q);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, multi-cycle
// freeze/reset sequences and randomized traffic against a rule-level model.
module tb_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset_0;
    logic [4:0] rs_id, rt_id, rw_ex, rw_mem;
    logic       use_rs_id, use_rt_id, branch_taken_id;
    logic       wreg_ex, m2reg_ex, wreg_mem, mem_busy;
    logic       stall_pc, stall_ifid, flush_ifid, bubble_idex, freeze;
    logic [1:0] fwd_a_ex, fwd_b_ex;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    int pass_cnt = 0;
    int tot_cnt  = 0;

    logic [1:0] m_fa, m_fb;

    always #5 clock = ~clock;

    hazard_ctrl dut (
        .clock           (clock),
        .reset_0         (reset_0),
        .rs_id           (rs_id),
        .rt_id           (rt_id),
        .use_rs_id       (use_rs_id),
        .use_rt_id       (use_rt_id),
        .branch_taken_id (branch_taken_id),
        .rw_ex           (rw_ex),
        .wreg_ex         (wreg_ex),
        .m2reg_ex        (m2reg_ex),
        .rw_mem          (rw_mem),
        .wreg_mem        (wreg_mem),
        .mem_busy        (mem_busy),
        .stall_pc        (stall_pc),
        .stall_ifid      (stall_ifid),
        .flush_ifid      (flush_ifid),
        .bubble_idex     (bubble_idex),
        .freeze          (freeze),
        .fwd_a_ex        (fwd_a_ex),
        .fwd_b_ex        (fwd_b_ex)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
`endif
    );

    typedef struct {
        logic [4:0] rs, rt, rwe, rwm;
        logic       urs, urt, br, we, m2r, wm, busy;
        logic [4:0] e_comb;   // {stall_pc, stall_ifid, flush_ifid, bubble_idex, freeze}
        logic [1:0] e_fa, e_fb;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                                input logic urt, input logic br, input logic [4:0] rwe,
                                input logic we, input logic m2r, input logic [4:0] rwm,
                                input logic wm, input logic busy, input logic [4:0] e_comb,
                                input logic [1:0] e_fa, input logic [1:0] e_fb);
        vec_t v;
        v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt; v.br = br;
        v.rwe = rwe; v.we = we; v.m2r = m2r; v.rwm = rwm; v.wm = wm; v.busy = busy;
        v.e_comb = e_comb; v.e_fa = e_fa; v.e_fb = e_fb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input vec_t v);
        rs_id = v.rs; use_rs_id = v.urs; rt_id = v.rt; use_rt_id = v.urt;
        branch_taken_id = v.br; rw_ex = v.rwe; wreg_ex = v.we; m2reg_ex = v.m2r;
        rw_mem = v.rwm; wreg_mem = v.wm; mem_busy = v.busy;
    endtask

    function automatic logic [4:0] comb_now();
        return {stall_pc, stall_ifid, flush_ifid, bubble_idex, freeze};
    endfunction

    // Reference model: hazard rules stated directly as priority decisions.
    function automatic logic m_lu();
        if (!(wreg_ex && m2reg_ex) || rw_ex == 0) return 1'b0;
        return (use_rs_id && rs_id == rw_ex) || (use_rt_id && rt_id == rw_ex);
    endfunction

    function automatic logic [4:0] m_comb();
        if (!reset_0) return 5'b00000;
        if (mem_busy) return 5'b11001;
        if (m_lu())   return 5'b11010;
        if (branch_taken_id) return 5'b00100;
        return 5'b00000;
    endfunction

    function automatic logic [1:0] m_src(input logic [4:0] src, input logic used);
        if (!used || src == 0) return 2'b00;
        if (wreg_ex && src == rw_ex && !m2reg_ex) return 2'b01;
        if (wreg_mem && src == rw_mem) return 2'b10;
        return 2'b00;
    endfunction

    // Call just before the active edge, with inputs stable.
    task automatic m_edge();
        if (!reset_0) begin
            m_fa = 2'b00; m_fb = 2'b00;
        end else if (mem_busy) begin
            m_fa = m_fa; m_fb = m_fb;
        end else if (m_lu()) begin
            m_fa = 2'b00; m_fb = 2'b00;
        end else begin
            m_fa = m_src(rs_id, use_rs_id);
            m_fb = m_src(rt_id, use_rt_id);
        end
    endtask

    initial begin
        // rs urs rt urt br | rwe we m2r | rwm wm busy | comb fa fb
        vecs[0]  = mk(5, 1, 0, 0, 0,  5, 1, 1,  0, 0, 0, 5'b11010, 2'b00, 2'b00); // lw r5 -> rs5 use
        vecs[1]  = mk(1, 1, 3, 1, 0,  3, 1, 0,  3, 1, 0, 5'b00000, 2'b00, 2'b01); // EX beats MEM on rt
        vecs[2]  = mk(7, 1, 7, 1, 0,  0, 0, 0,  7, 1, 0, 5'b00000, 2'b10, 2'b10); // MEM forward
        vecs[3]  = mk(0, 1, 0, 1, 0,  0, 1, 1,  0, 1, 0, 5'b00000, 2'b00, 2'b00); // r0 never
        vecs[4]  = mk(4, 0, 4, 1, 0,  4, 1, 0,  0, 0, 0, 5'b00000, 2'b00, 2'b01); // unused rs
        vecs[5]  = mk(9, 1, 0, 0, 1,  9, 1, 0,  0, 0, 1, 5'b11001, 2'b00, 2'b01); // freeze holds
        vecs[6]  = mk(0, 0, 0, 0, 1,  0, 0, 0,  0, 0, 0, 5'b00100, 2'b00, 2'b00); // plain flush
        vecs[7]  = mk(0, 0, 6, 1, 1,  6, 1, 1,  0, 0, 0, 5'b11010, 2'b00, 2'b00); // branch under lu
        vecs[8]  = mk(0, 0, 0, 0, 1,  6, 1, 1,  0, 0, 0, 5'b00100, 2'b00, 2'b00); // branch after
        vecs[9]  = mk(8, 0, 0, 0, 0,  8, 1, 1,  0, 0, 0, 5'b00000, 2'b00, 2'b00); // load, src unused
        vecs[10] = mk(2, 1, 2, 1, 0,  2, 1, 0,  2, 1, 0, 5'b00000, 2'b01, 2'b01); // both EX
        vecs[11] = mk(2, 1, 2, 1, 1,  2, 1, 1,  0, 0, 1, 5'b11001, 2'b01, 2'b01); // freeze beats lu
        vecs[12] = mk(3, 1, 0, 0, 0,  3, 0, 1,  0, 0, 0, 5'b00000, 2'b00, 2'b00); // no wreg, no lu

        reset_0 = 1'b0;
        drive(vecs[11]);
        m_fa = 2'b00; m_fb = 2'b00;
        repeat (2) @(posedge clock);
        #1;
        chk("reset comb", 16'(comb_now()), 16'h0);
        chk("reset fwd", 16'({fwd_a_ex, fwd_b_ex}), 16'h0);

        @(negedge clock);
        reset_0 = 1'b1;
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("vec%0d comb", i), 16'(comb_now()), 16'(vecs[i].e_comb));
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d fwd", i), 16'({fwd_a_ex, fwd_b_ex}), 16'({vecs[i].e_fa, vecs[i].e_fb}));
            @(negedge clock);
        end

        // Set fwd to {10,01}, then three busy cycles with a taken branch.
        drive(mk(7, 1, 3, 1, 0, 3, 1, 0, 7, 1, 0, 5'b0, 2'b0, 2'b0));
        @(posedge clock); #1;
        chk("pre-freeze fwd", 16'({fwd_a_ex, fwd_b_ex}), 16'({2'b10, 2'b01}));
        @(negedge clock);
        for (int c = 0; c < 3; c++) begin
            drive(mk(1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 5'b0, 2'b0, 2'b0));
            #1;
            chk($sformatf("busy%0d comb", c), 16'(comb_now()), 16'(5'b11001));
            @(posedge clock); #1;
            chk($sformatf("busy%0d fwd", c), 16'({fwd_a_ex, fwd_b_ex}), 16'({2'b10, 2'b01}));
            @(negedge clock);
        end
        mem_busy = 1'b0;
        #1;
        chk("post-busy flush", 16'(comb_now()), 16'(5'b00100));
        @(posedge clock); #1;
        chk("post-busy fwd", 16'({fwd_a_ex, fwd_b_ex}), 16'({2'b01, 2'b01}));

        // Reset in the middle of a wait, then normal evaluation on the first edge.
        @(negedge clock);
        mem_busy = 1'b1;
        @(posedge clock); #2;
        reset_0 = 1'b0;
        #1;
        chk("mid-wait reset comb", 16'(comb_now()), 16'h0);
        chk("mid-wait reset fwd", 16'({fwd_a_ex, fwd_b_ex}), 16'h0);
        @(negedge clock);
        reset_0 = 1'b1;
        drive(mk(0, 0, 3, 1, 0, 3, 1, 0, 0, 0, 0, 5'b0, 2'b0, 2'b0));
        #1;
        chk("post-reset comb", 16'(comb_now()), 16'h0);
        @(posedge clock); #1;
        chk("post-reset fwd", 16'({fwd_a_ex, fwd_b_ex}), 16'({2'b00, 2'b01}));

        // Randomized traffic over a small register range to provoke collisions.
        m_fa = fwd_a_ex === 2'b00 ? 2'b00 : 2'bxx;
        m_fb = fwd_b_ex === 2'b01 ? 2'b01 : 2'bxx;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clock);
            rs_id = 5'($urandom_range(0, 3));
            rt_id = 5'($urandom_range(0, 3));
            rw_ex = 5'($urandom_range(0, 3));
            rw_mem = 5'($urandom_range(0, 3));
            use_rs_id = 1'($urandom); use_rt_id = 1'($urandom);
            branch_taken_id = 1'($urandom); wreg_ex = 1'($urandom);
            m2reg_ex = 1'($urandom); wreg_mem = 1'($urandom);
            mem_busy = ($urandom_range(0, 4) == 0);
            #1;
            chk("rand comb", 16'(comb_now()), 16'(m_comb()));
            m_edge();
            @(posedge clock); #1;
            chk("rand fwd", 16'({fwd_a_ex, fwd_b_ex}), 16'({m_fa, m_fb}));
        end

`ifdef HAZARD_STATS_EN
        @(negedge clock);
        reset_0 = 1'b0;
        #1;
        reset_0 = 1'b1;
        mem_busy = 1'b1;
        repeat (70000) @(posedge clock);
        #1;
        chk("stall_cnt sat", stall_cnt, 16'hFFFF);
        reset_0 = 1'b0;
        #1;
        chk("stall_cnt reset", stall_cnt, 16'h0);
        chk("flush_cnt reset", flush_cnt, 16'h0);
        reset_0 = 1'b1;
`endif

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
